fft_out_buffer: RTL and testbench



---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_buf_ram.sv | 38 +++
 rtl/fft_out_buffer.sv | 173 +++++++++++++++++
 tb/tb_fft_out_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output buffer: default sizes, the capture
// state enum and the L1 complex magnitude helper used for peak tracking.
package fft_pkg;

  localparam int FFT_N  = 32;
  localparam int FFT_DW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } fft_buf_state_e;

  // |re| + |im| on sign-extended 32-bit components. Working one bit wider
  // than the inputs keeps |most-negative| representable.
  function automatic logic [32:0] cabs_l1(input logic signed [31:0] re,
                                          input logic signed [31:0] im);
    logic signed [32:0] re_x;
    logic signed [32:0] im_x;
    re_x = 33'(re);
    im_x = 33'(im);
    if (re_x < 0) re_x = -re_x;
    if (im_x < 0) im_x = -im_x;
    return $unsigned(re_x + im_x);
  endfunction

endpackage

// File: rtl/fft_buf_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read and write to the same address in one cycle returns the old word.
// The array itself is never reset; only the read register is.
module fft_buf_ram #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array: plain write, no reset so it maps onto a memory macro.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_out_buffer.sv
// Captures one frame of FFT output into a local buffer and exposes it through
// a synchronous read port with busy/done status.
// Optional peak tracking is compiled in when FFT_PEAK_EN is defined; otherwise
// peak_idx/peak_mag are tied to zero.
// Write path handshake: a sample is taken on any cycle where fft_out_valid is
// high while ARMED or CAPTURE; there is no backpressure toward the FFT.
module fft_out_buffer
  import fft_pkg::*;
#(
  parameter  int N  = FFT_N,
  parameter  int DW = FFT_DW,
  localparam int AW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 fft_out_valid,
  input  logic signed [DW-1:0] fft_dout_r,
  input  logic signed [DW-1:0] fft_dout_i,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [2*DW-1:0]      rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        peak_idx,
  output logic [DW:0]          peak_mag,
  output fft_buf_state_e       dbg_state
);

  fft_buf_state_e state_q;
  logic [AW-1:0]  wr_idx_q;
  logic           busy_q;
  logic           done_q;
  logic           rd_valid_q;

  logic           start_taken;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [2*DW-1:0] wr_data;

  // start is only honoured between frames; mid-frame pulses are dropped.
  assign start_taken = start && ((state_q == IDLE) || (state_q == DONE));
  assign wr_en       = fft_out_valid && ((state_q == ARMED) || (state_q == CAPTURE));
  assign wr_addr     = (state_q == ARMED) ? '0 : wr_idx_q;
  assign wr_data     = {fft_dout_r, fft_dout_i};

  // Capture FSM with registered busy/done decodes of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_taken) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
          end
        end
        ARMED: begin
          if (fft_out_valid) begin
            state_q  <= CAPTURE;
            wr_idx_q <= AW'(1);
          end
        end
        CAPTURE: begin
          if (fft_out_valid) begin
            if (wr_idx_q == AW'(N - 1)) begin
              state_q  <= DONE;
              wr_idx_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              wr_idx_q <= wr_idx_q + AW'(1);
            end
          end
        end
        DONE: begin
          if (start_taken) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          wr_idx_q <= '0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // rd_valid marks the cycle after each read request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_valid_q <= 1'b0;
    else          rd_valid_q <= rd_en;
  end

  fft_buf_ram #(
    .DEPTH (N),
    .WIDTH (2 * DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef FFT_PEAK_EN
  logic signed [31:0] re_ext;
  logic signed [31:0] im_ext;
  logic [32:0]        mag_wide;
  logic               mag_unused;
  logic [DW:0]        sample_mag;
  logic [DW:0]        peak_mag_q, peak_mag_d;
  logic [AW-1:0]      peak_idx_q, peak_idx_d;

  assign re_ext     = 32'(fft_dout_r);
  assign im_ext     = 32'(fft_dout_i);
  assign mag_wide   = cabs_l1(re_ext, im_ext);
  assign sample_mag = mag_wide[DW:0];
  assign mag_unused = ^mag_wide[32:DW+1];

  // Running peak: entry 0 seeds it, later samples must be strictly larger
  // so ties keep the lower bin; a new arm clears it.
  always_comb begin
    peak_mag_d = peak_mag_q;
    peak_idx_d = peak_idx_q;
    if (start_taken) begin
      peak_mag_d = '0;
      peak_idx_d = '0;
    end else if (wr_en && (state_q == ARMED)) begin
      peak_mag_d = sample_mag;
      peak_idx_d = '0;
    end else if (wr_en && (sample_mag > peak_mag_q)) begin
      peak_mag_d = sample_mag;
      peak_idx_d = wr_addr;
    end
  end

  // Peak registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_mag_q <= '0;
      peak_idx_q <= '0;
    end else begin
      peak_mag_q <= peak_mag_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  assign peak_mag = peak_mag_q;
  assign peak_idx = peak_idx_q;
`else
  assign peak_mag = '0;
  assign peak_idx = '0;
`endif

endmodule

// File: tb/tb_fft_out_buffer.sv
// Bench for fft_out_buffer: directed frames, a vector table, and randomized
// traffic against a frame-level model (captured count + array image).
module tb_fft_out_buffer;
  import fft_pkg::*;

  localparam int N  = 32;
  localparam int DW = 16;
  localparam int AW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 fft_out_valid = 1'b0;
  logic signed [DW-1:0] fft_dout_r = '0;
  logic signed [DW-1:0] fft_dout_i = '0;
  logic                 rd_en = 1'b0;
  logic [AW-1:0]        rd_addr = '0;
  logic [2*DW-1:0]      rd_data;
  logic                 rd_valid;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        peak_idx;
  logic [DW:0]          peak_mag;
  fft_buf_state_e       dbg_state;

  always #5 clk = ~clk;

  fft_out_buffer #(.N(N), .DW(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .fft_out_valid (fft_out_valid),
    .fft_dout_r    (fft_dout_r),
    .fft_dout_i    (fft_dout_i),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .done          (done),
    .peak_idx      (peak_idx),
    .peak_mag      (peak_mag),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  logic [2*DW-1:0] m_mem [N];
  int              m_phase = 0;  // 0 no frame, 1 collecting, 2 frame complete
  int              m_cnt   = 0;
  logic [2*DW-1:0] m_rd_data = '0;
  logic            m_rd_valid = 1'b0;
  logic [2*DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peak of a complete frame: first bin with the largest |re|+|im|.
  task automatic model_peak(output int idx, output int mag);
    idx = 0;
    mag = 0;
    if (m_phase == 2) begin
      for (int i = 0; i < N; i++) begin
        int r;
        int q;
        int m;
        r = int'($signed(m_mem[i][2*DW-1:DW]));
        q = int'($signed(m_mem[i][DW-1:0]));
        m = ((r < 0) ? -r : r) + ((q < 0) ? -q : q);
        if (i == 0 || m > mag) begin
          mag = m;
          idx = i;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    int pi;
    int pm;
    check("busy", 64'(busy), 64'(m_phase == 1));
    check("done", 64'(done), 64'(m_phase == 2));
    check("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    check("rd_data", 64'(rd_data), 64'(m_rd_data));
`ifdef FFT_PEAK_EN
    if (m_phase != 1 || m_cnt == 0) begin
      model_peak(pi, pm);
      check("peak_idx", 64'(peak_idx), 64'(pi));
      check("peak_mag", 64'(peak_mag), 64'(pm));
    end
`else
    pi = 0;
    pm = 0;
    check("peak_idx_off", 64'(peak_idx), 64'(pi));
    check("peak_mag_off", 64'(peak_mag), 64'(pm));
`endif
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic cycle(input logic st, input logic v, input logic [DW-1:0] r,
                       input logic [DW-1:0] q, input logic rden, input logic [AW-1:0] addr);
    start = st;
    fft_out_valid = v;
    fft_dout_r = r;
    fft_dout_i = q;
    rd_en = rden;
    rd_addr = addr;
    @(posedge clk);
    if (rden) begin
      m_rd_data  = m_mem[addr];
      m_rd_valid = 1'b1;
    end else begin
      m_rd_valid = 1'b0;
    end
    if (m_phase != 1) begin
      if (st) begin
        m_phase = 1;
        m_cnt   = 0;
      end
    end else if (v) begin
      m_mem[m_cnt] = {r, q};
      m_cnt++;
      if (m_cnt == N) m_phase = 2;
    end
    #1;
    compare_outputs();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < N; a++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
      exp_q.push_back(m_mem[a]);
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, "_done"}, 64'(done), 64'(1));
  endtask

  task automatic random_frame(input int force_idx, input logic [2*DW-1:0] force_val);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < N; k++) begin
      logic [2*DW-1:0] w;
      w = (k == force_idx) ? force_val : 32'($urandom);
      cycle(1'b0, 1'b1, w[2*DW-1:DW], w[DW-1:0], 1'b0, '0);
    end
  endtask

  task automatic do_async_reset();
    start = 1'b0;
    fft_out_valid = 1'b0;
    rd_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_rd_valid", 64'(rd_valid), 64'(0));
    check("arst_rd_data", 64'(rd_data), 64'(0));
    m_phase = 0;
    m_cnt = 0;
    m_rd_valid = 1'b0;
    m_rd_data = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    compare_outputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            st;
    logic            v;
    logic [DW-1:0]   r;
    logic [DW-1:0]   q;
    logic            rden;
    logic [AW-1:0]   addr;
    logic            e_busy;
    logic            e_done;
    logic            e_rdv;
    logic [2*DW-1:0] e_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset state.
    #3;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_rd_valid", 64'(rd_valid), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    check("reset_peak_idx", 64'(peak_idx), 64'(0));
    check("reset_peak_mag", 64'(peak_mag), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Valid while idle is ignored; start with a valid sample only arms.
    cycle(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, '0);
    cycle(1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, '0);
    check("armed_busy", 64'(busy), 64'(1));

    // Basic frame: re=k, im=-k.
    for (int k = 0; k < N; k++) begin
      cycle(1'b0, 1'b1, DW'(k), DW'(-k), 1'b0, '0);
      check("basic_done_timing", 64'(done), 64'(k == N - 1));
    end

    // Post-done samples are ignored.
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0, '0);
    read_all("post_done");

    // Table of hand-computed vectors on the completed basic frame.
    vecs[0] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b1, 5'd5,  1'b0, 1'b1, 1'b1, 32'h0005_FFFB};
    vecs[1] = '{1'b0, 1'b1, 16'h7FFF, 16'h0000, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0005_FFFB};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'd31, 1'b0, 1'b1, 1'b1, 32'h001F_FFE1};
    vecs[3] = '{1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 5'd1,  1'b0, 1'b1, 1'b1, 32'h0001_FFFF};
    vecs[4] = '{1'b1, 1'b1, 16'h7FFF, 16'h0000, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0001_FFFF};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 32'h0005_FFFB};
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].st, vecs[i].v, vecs[i].r, vecs[i].q, vecs[i].rden, vecs[i].addr);
      check("vec_busy", 64'(busy), 64'(vecs[i].e_busy));
      check("vec_done", 64'(done), 64'(vecs[i].e_done));
      check("vec_rd_valid", 64'(rd_valid), 64'(vecs[i].e_rdv));
      check("vec_rd_data", 64'(rd_data), 64'(vecs[i].e_data));
    end

    // Gapped stream (already armed): valid toggles, re carries the bin index.
    for (int j = 0; j < 2 * N; j++) begin
      cycle(j == 10, (j % 2) == 0, DW'(j / 2), DW'($urandom), 1'b0, '0);
      if (j < 2 * N - 2) check("gap_busy", 64'(busy), 64'(1));
    end
    check("gap_done", 64'(done), 64'(1));
    for (int a = 0; a < N; a++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(a));
      check("gap_entry_re", 64'(rd_data[2*DW-1:DW]), 64'(a));
    end

    // Read/write collision: previous frame leaves 0x0AAA_0BBB in entry 3.
    random_frame(3, 32'h0AAA_0BBB);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b0, '0);
    cycle(1'b0, 1'b1, 16'h1234, 16'h0001, 1'b1, 5'd3);
    check("collide_old", 64'(rd_data), 64'h0AAA_0BBB);
    cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b1, 5'd3);
    check("collide_new", 64'(rd_data), 64'h1234_0001);
    for (int k = 5; k < N; k++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b0, '0);
    check("collide_frame_done", 64'(done), 64'(1));

    // Peak frame: bins 7 and 20 tie at the largest magnitude.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < N; k++) begin
      if (k == 7 || k == 20) cycle(1'b0, 1'b1, 16'h8000, 16'h0000, 1'b0, '0);
      else cycle(1'b0, 1'b1, DW'(int'($urandom_range(0, 2000)) - 1000),
                 DW'(int'($urandom_range(0, 2000)) - 1000), 1'b0, '0);
    end
`ifdef FFT_PEAK_EN
    check("peak_tie_idx", 64'(peak_idx), 64'(7));
    check("peak_tie_mag", 64'(peak_mag), 64'(32768));
`else
    check("peak_off_idx", 64'(peak_idx), 64'(0));
    check("peak_off_mag", 64'(peak_mag), 64'(0));
`endif

    // Reset mid-frame, then a fresh frame completes normally.
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, DW'($urandom), DW'($urandom), 1'b0, '0);
    do_async_reset();
    idle_cycle();
    random_frame(-1, '0);
    check("after_reset_done", 64'(done), 64'(1));
    read_all("after_reset");

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            DW'($urandom), DW'($urandom), $urandom_range(0, 1) == 1,
            AW'($urandom_range(0, N - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
